// File: rtl/rom_read_arbiter_pkg.sv
// Shared definitions for the ROM read arbiter: state encoding, default sizes, counter width.
// Optional feature macro: ROM_ARB_STATS_EN (per-requester grant counters).
package rom_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 4;
  localparam int DW_DEF   = 4;
  localparam int CNT_W    = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    CAPTURE = ST_CAPTURE,
    RESP    = ST_RESP
  } state_t;

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester-side bundle: per-requester request/response valid-ready channels and shared read data.
interface rom_arb_if
  import rom_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
  logic [NREQ-1:0]    resp_ready;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/rom_read_arbiter_rr_picker.sv
// Combinational round-robin select: first valid at or after the pointer, wrapping to 0.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  // Scan farthest offset first so the nearest valid requester overwrites.
  always_comb begin
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (i_valid[j]) begin
        o_grant    = '0;
        o_grant[j] = 1'b1;
        o_idx      = PW'(j);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM among NREQ requesters, one read in flight.
// Define ROM_ARB_STATS_EN to add o_grant_cnt, saturating 16-bit per-requester grant counters.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  rom_arb_if.slave          bus,
  output logic              o_rom_en,
  output logic [AW-1:0]     o_rom_addr,
  input  logic [DW-1:0]     i_rom_data
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] o_grant_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_win;
  logic              r_rom_en;
  logic [AW-1:0]     r_rom_addr;
  logic [NREQ-1:0]   r_resp_valid;
  logic [DW-1:0]     r_resp_data;

  logic [NREQ-1:0]   w_grant;
  logic [PW-1:0]     w_idx;
  logic              w_any;
  logic              w_accept;
  logic [AW-1:0]     w_sel_addr;
  logic [PW-1:0]     w_ptr_nxt;

  rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_valid (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Ready is suppressed while reset is asserted so nothing looks accepted during reset.
  assign w_accept      = (r_state == IDLE) && i_rst_n && w_any;
  assign bus.req_ready = w_accept ? w_grant : '0;
  assign w_sel_addr    = bus.req_addr[int'(w_idx)*AW +: AW];
  assign w_ptr_nxt     = (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;

  assign o_rom_en       = r_rom_en;
  assign o_rom_addr     = r_rom_addr;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_win        <= '0;
      r_rom_en     <= 1'b0;
      r_rom_addr   <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win      <= w_idx;
            r_rom_en   <= 1'b1;
            r_rom_addr <= w_sel_addr;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_rom_en <= 1'b0;
          r_state  <= CAPTURE;
        end
        CAPTURE: begin
          r_resp_data  <= i_rom_data;
          r_resp_valid <= NREQ'(1) << r_win;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready[r_win]) begin
            r_resp_valid <= '0;
            r_ptr        <= w_ptr_nxt;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ROM_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] r_grant_cnt;

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    always_ff @(posedge i_clk) begin
      if (!i_rst_n)
        r_grant_cnt[g] <= '0;
      else if (w_accept && w_grant[g] && (r_grant_cnt[g] != {CNT_W{1'b1}}))
        r_grant_cnt[g] <= r_grant_cnt[g] + 1'b1;
    end
  end

  assign o_grant_cnt = r_grant_cnt;
`endif

endmodule
